// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and FSM state type for the 32x8 RAM and its burst master
package ram_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 5;
  localparam int MEM_DEPTH = 32;
  localparam int LEN_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } ram_ms_state_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// rtl/ram_burst_master_if.sv - client command/data and RAM-side signals of the burst master
interface ram_burst_master_if;
  import ram_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              busy;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, ram_rdata,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
           ram_wr_en, ram_rd_en, ram_addr, ram_wdata
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, ram_rdata,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
           ram_wr_en, ram_rd_en, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - read/write burst controller for the 32x8 single-port synchronous RAM
module ram_burst_master
  import ram_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ram_burst_master_if.master  bus
);

  ram_ms_state_t     state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;
  logic              rd_valid_q;
  logic              done_q;
  logic              beat_go;
  logic              last_op;

  // A beat moves the counters: every READ cycle, or a WRITE cycle with data present.
  assign beat_go = (state == READ) || ((state == WRITE) && bus.wr_valid);
  assign last_op = beat_go && (beats_left == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= (state == READ);
      done_q     <= last_op;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr   <= bus.cmd_addr;
            beats_left <= bus.cmd_len;
            state      <= bus.cmd_wr ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (beat_go) begin
            cur_addr   <= cur_addr + ADDR_W'(1);
            beats_left <= beats_left - LEN_W'(1);
            if (beats_left == '0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.ram_wr_en = (state == WRITE) && bus.wr_valid;
  assign bus.ram_rd_en = (state == READ);
  // RAM-side address and data are forced to zero whenever the master is idle.
  assign bus.ram_addr  = (state == IDLE)  ? '0 : cur_addr;
  assign bus.ram_wdata = (state == WRITE) ? bus.wr_data : '0;
  assign bus.rd_data   = bus.ram_rdata;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// tb/tb_ram_burst_master.sv - randomized self-checking bench for ram_burst_master
module tb_ram_burst_master;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_master_if bus ();

  ram_burst_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM behaviour: synchronous write, registered read
  logic [DATA_W-1:0] ram_mem [MEM_DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wr_en) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_rd_en) bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  // reference contents and per-beat stimulus
  logic [DATA_W-1:0] exp_mem [MEM_DEPTH];
  logic [DATA_W-1:0] wbuf [8];
  int                gaps [8];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a, input int i);
    return ADDR_W'((int'(a) + i) % MEM_DEPTH);
  endfunction

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    logic [ADDR_W-1:0] ai;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = a; bus.cmd_len = l;
    @(negedge clk);
    check_val("wr_cmd_ready", bus.cmd_ready, 1);
    check_val("wr_idle_wen", bus.ram_wr_en, 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = ADDR_W'($urandom);
    for (int i = 0; i <= int'(l); i++) begin
      ai = beat_addr(a, i);
      for (int g = 0; g < gaps[i]; g++) begin
        bus.wr_valid = 1'b0; bus.wr_data = DATA_W'($urandom);
        @(negedge clk);
        check_val("wr_gap_wen", bus.ram_wr_en, 0);
        check_val("wr_gap_addr", bus.ram_addr, ai);
        check_val("wr_gap_done", bus.done, 0);
        @(posedge clk); #1;
      end
      bus.wr_valid = 1'b1; bus.wr_data = wbuf[i];
      @(negedge clk);
      check_val("wr_wen", bus.ram_wr_en, 1);
      check_val("wr_addr", bus.ram_addr, ai);
      check_val("wr_wdata", bus.ram_wdata, wbuf[i]);
      check_val("wr_busy", {bus.busy, bus.cmd_ready, bus.wr_ready}, 3'b101);
      check_val("wr_beat_done", bus.done, 0);
      exp_mem[ai] = wbuf[i];
      @(posedge clk); #1;
      bus.wr_valid = 1'b0;
    end
    @(negedge clk);
    check_val("wr_done", bus.done, 1);
    check_val("wr_end_ready", {bus.busy, bus.cmd_ready, bus.ram_wr_en}, 3'b010);
  endtask

  // pending: command already presented by the previous call; hold: keep it asserted
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                         input bit pending, input bit hold);
    if (!pending) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = a; bus.cmd_len = l;
      @(negedge clk);
      check_val("rd_cmd_ready", bus.cmd_ready, 1);
    end
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      @(negedge clk);
      check_val("rd_ren", bus.ram_rd_en, 1);
      check_val("rd_addr", bus.ram_addr, beat_addr(a, i));
      check_val("rd_hold_off", {bus.busy, bus.cmd_ready}, 2'b10);
      check_val("rd_beat_done", bus.done, 0);
      check_val("rd_valid", bus.rd_valid, (i > 0));
      if (i > 0) check_val("rd_data", bus.rd_data, exp_mem[beat_addr(a, i - 1)]);
      @(posedge clk);
    end
    @(negedge clk);
    check_val("rd_last_valid", bus.rd_valid, 1);
    check_val("rd_last_data", bus.rd_data, exp_mem[beat_addr(a, int'(l))]);
    check_val("rd_done", bus.done, 1);
    check_val("rd_end_ready", {bus.cmd_ready, bus.ram_rd_en}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [LEN_W-1:0]  rl;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    for (int i = 0; i < 8; i++) gaps[i] = 0;

    repeat (2) @(negedge clk);
    check_val("rst_outputs", {bus.rd_valid, bus.done, bus.busy, bus.ram_wr_en, bus.ram_rd_en}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_cmd_ready", bus.cmd_ready, 1);

    // fill memory so every later read has a known expectation
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = DATA_W'($urandom);
      do_write(ADDR_W'(b * 8), 3'd7);
    end

    wbuf[0] = 8'hA5;
    do_write(5'd5, 3'd0);
    do_read(5'd5, 3'd0, 1'b0, 1'b0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(5'd30, 3'd3);
    do_read(5'd30, 3'd3, 1'b0, 1'b0);
    check_val("wrap_mem0", exp_mem[0], 8'h33);

    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    gaps[1] = 2;
    do_write(5'd8, 3'd1);
    gaps[1] = 0;

    // second command stays asserted through the 8-beat read and is taken at done
    do_read(5'd12, 3'd7, 1'b0, 1'b1);
    do_read(5'd12, 3'd7, 1'b1, 1'b0);

    // reset after three issued beats of an eight-beat read
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 5'd20; bus.cmd_len = 3'd7;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_outputs", {bus.rd_valid, bus.done, bus.busy, bus.ram_wr_en, bus.ram_rd_en}, 5'b0);
    check_val("mid_rst_addr", bus.ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("post_rst_quiet", {bus.rd_valid, bus.done, bus.busy, bus.cmd_ready}, 4'b0001);
    end
    do_read(5'd0, LEN_W'($urandom), 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      ra = ADDR_W'($urandom);
      rl = LEN_W'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        for (int i = 0; i < 8; i++) begin
          wbuf[i] = DATA_W'($urandom);
          gaps[i] = $urandom_range(2, 0);
        end
        do_write(ra, rl);
      end else begin
        do_read(ra, rl, 1'b0, 1'b0);
      end
    end

    @(negedge clk);
    check_val("final_idle", {bus.busy, bus.rd_valid, bus.done}, 3'b000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
